// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared 256x8 memory: round-robin with grant parking,
// owner lock and registered read return. Define ARB_TIMEOUT_EN to enable forced lock release.
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   last_r;
    logic   last_nxt_s;
    logic   locked_r;
    logic   locked_nxt_s;
    logic   xfer0_s;
    logic   xfer1_s;
    logic   fire_s;

    assign xfer0_s = req0 && (state_r == ST_OWN0);
    assign xfer1_s = req1 && (state_r == ST_OWN1);

    // Memory port follows the owner only while it is actually requesting
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (xfer0_s) begin
            mem_addr = addr0;
            mem_din  = wdata0;
            mem_we   = we0;
        end else if (xfer1_s) begin
            mem_addr = addr1;
            mem_din  = wdata1;
            mem_we   = we1;
        end else begin
            mem_we   = 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_MAX) + 1;

    logic [CNT_W-1:0] lock_cnt_r;
    logic             other_req_s;

    // Request of whichever side is waiting on the current owner
    always_comb begin
        other_req_s = 1'b0;
        if (state_r == ST_OWN0) begin
            other_req_s = req1;
        end else if (state_r == ST_OWN1) begin
            other_req_s = req0;
        end else begin
            other_req_s = 1'b0;
        end
    end

    assign fire_s = locked_r && other_req_s && (lock_cnt_r == CNT_W'(LOCK_MAX - 1));

    // Counts locked cycles that starve the other requester
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_r <= '0;
        end else if (!locked_nxt_s || (state_nxt_s != state_r)) begin
            lock_cnt_r <= '0;
        end else if (locked_r && other_req_s) begin
            lock_cnt_r <= lock_cnt_r + CNT_W'(1);
        end else begin
            lock_cnt_r <= lock_cnt_r;
        end
    end
`else
    assign fire_s = 1'b0;
`endif

    // Next ownership: lock is updated by this cycle's transfer before deciding to hand over
    always_comb begin
        state_nxt_s  = state_r;
        last_nxt_s   = last_r;
        locked_nxt_s = locked_r;
        if (xfer0_s) begin
            locked_nxt_s = lock0;
        end else if (xfer1_s) begin
            locked_nxt_s = lock1;
        end else begin
            locked_nxt_s = locked_r;
        end
        if (fire_s) begin
            locked_nxt_s = 1'b0;
        end else begin
            locked_nxt_s = locked_nxt_s;
        end
        case (state_r)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_nxt_s = last_r ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_nxt_s = ST_OWN0;
                end else if (req1) begin
                    state_nxt_s = ST_OWN1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!locked_nxt_s && req1) begin
                    state_nxt_s = ST_OWN1;
                    last_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!locked_nxt_s && req0) begin
                    state_nxt_s = ST_OWN0;
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_OWN1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Arbitration state and registered grant/timeout outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            last_r   <= 1'b1;
            locked_r <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            last_r   <= last_nxt_s;
            locked_r <= locked_nxt_s;
            gnt0     <= (state_nxt_s == ST_OWN0);
            gnt1     <= (state_nxt_s == ST_OWN1);
            timeout  <= fire_s;
        end
    end

    // Read data return, one cycle after the read transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= xfer0_s && !we0;
            rvalid1 <= xfer1_s && !we1;
            if (xfer0_s && !we0) begin
                rdata0 <= mem_dout;
            end else begin
                rdata0 <= rdata0;
            end
            if (xfer1_s && !we1) begin
                rdata1 <= mem_dout;
            end else begin
                rdata1 <= rdata1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against an ownership-level reference model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset, mem_init;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1, mem_we, timeout;
    logic [7:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;
    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .timeout(timeout)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 0) ? 8'h22 : 8'(i * 3 + 1);
    endfunction

    // Behavioural 256x8 memory with combinational read
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Reference model: owner index (2 = nobody), round-robin memory of the last loser, lock flag
    int         m_own = 2;
    bit         m_last = 1'b1;
    bit         m_locked = 1'b0;
    bit         m_rv [2];
    logic [7:0] m_rd [2];
    logic [7:0] ref_mem [256];
    logic       seen_we;

    task automatic model_step();
        bit         r [2];
        bit         w [2];
        bit         l [2];
        logic [7:0] a [2];
        logic [7:0] d [2];
        int         x;
        bit         xfer;
        r[0] = req0; r[1] = req1; w[0] = we0; w[1] = we1; l[0] = lock0; l[1] = lock1;
        a[0] = addr0; a[1] = addr1; d[0] = wdata0; d[1] = wdata1;
        x = m_own;
        xfer = (x != 2) && r[x];
        if (xfer && w[x]) ref_mem[a[x]] = d[x];
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (reset) begin
            m_own = 2; m_last = 1'b1; m_locked = 1'b0;
            m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        end else if (x == 2) begin
            if (r[0] && r[1]) m_own = m_last ? 0 : 1;
            else if (r[0]) m_own = 0;
            else if (r[1]) m_own = 1;
        end else begin
            if (xfer) begin
                m_locked = l[x];
                if (!w[x]) begin
                    m_rv[x] = 1'b1;
                    m_rd[x] = ref_mem[a[x]];
                end
            end
            if (!m_locked && r[1-x]) begin
                m_own = 1 - x;
                m_last = (x == 1);
            end
        end
    endtask

    // One clock: check memory drive before the edge, registered outputs after it
    task automatic tick(input bit chk_en);
        logic       e_we;
        logic [7:0] e_addr, e_din;
        #1;
        e_we = 1'b0; e_addr = 8'h00; e_din = 8'h00;
        if (m_own == 0 && req0) begin
            e_we = we0; e_addr = addr0; e_din = wdata0;
        end else if (m_own == 1 && req1) begin
            e_we = we1; e_addr = addr1; e_din = wdata1;
        end
        if (chk_en) begin
            chk1("mem_we", mem_we, e_we);
            chk8("mem_addr", mem_addr, e_addr);
            chk8("mem_din", mem_din, e_din);
        end
        seen_we = mem_we;
        model_step();
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk1("gnt0", gnt0, m_own == 0);
            chk1("gnt1", gnt1, m_own == 1);
            chk1("rvalid0", rvalid0, m_rv[0]);
            chk1("rvalid1", rvalid1, m_rv[1]);
            chk8("rdata0", rdata0, m_rd[0]);
            chk8("rdata1", rdata1, m_rd[1]);
            chk1("timeout", timeout, 1'b0);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       l0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       l1;
        logic       xwe;
        logic       g0, g1, v0, v1;
        logic [7:0] rd0, rd1;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // rst r0 w0 a0 d0 l0 | r1 w1 a1 d1 l1 | mem_we | g0 g1 v0 v1 | rd0 rd1
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 8'h07};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 8'h07};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hEE, 1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h07};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hEE, 1'b0, 1'b1, 1'b1, 8'h01, 8'h27, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h07};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hEE, 1'b0, 1'b1, 1'b1, 8'h02, 8'h61, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h07};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'hEE, 1'b0, 1'b1, 1'b1, 8'h03, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 8'h07};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 8'h07};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h27, 8'h07};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h61, 8'h07};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h07};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        reset = 1'b1; mem_init = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00; lock0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00; lock1 = 1'b0;
        tick(1'b0);
        tick(1'b0);
        chk1("reset gnt0", gnt0, 1'b0);
        chk1("reset gnt1", gnt1, 1'b0);
        chk1("reset rvalid0", rvalid0, 1'b0);
        chk1("reset rvalid1", rvalid1, 1'b0);
        chk8("reset rdata0", rdata0, 8'h00);
        chk8("reset rdata1", rdata1, 8'h00);
        chk1("reset timeout", timeout, 1'b0);
        mem_init = 1'b0;

        // Directed vectors: first read, tie-break and interleave, locked load then readback
        for (int k = 0; k < 16; k++) begin
            reset = tbl[k].rst;
            req0 = tbl[k].r0; we0 = tbl[k].w0; addr0 = tbl[k].a0; wdata0 = tbl[k].d0; lock0 = tbl[k].l0;
            req1 = tbl[k].r1; we1 = tbl[k].w1; addr1 = tbl[k].a1; wdata1 = tbl[k].d1; lock1 = tbl[k].l1;
            tick(1'b0);
            chk1($sformatf("row%0d mem_we", k), seen_we, tbl[k].xwe);
            chk1($sformatf("row%0d gnt0", k), gnt0, tbl[k].g0);
            chk1($sformatf("row%0d gnt1", k), gnt1, tbl[k].g1);
            chk1($sformatf("row%0d rvalid0", k), rvalid0, tbl[k].v0);
            chk1($sformatf("row%0d rvalid1", k), rvalid1, tbl[k].v1);
            chk8($sformatf("row%0d rdata0", k), rdata0, tbl[k].rd0);
            chk8($sformatf("row%0d rdata1", k), rdata1, tbl[k].rd1);
        end
        reset = 1'b0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;

        // Parked owner 0 with a pulsing request: zero-latency transfers, never back to idle
        for (int i = 0; i < 8; i++) begin
            req0 = (i % 2 == 0); we0 = 1'b0; addr0 = 8'(i);
            tick(1'b1);
            chk1("park gnt0", gnt0, 1'b1);
            chk1("park rvalid0", rvalid0, (i % 2 == 0));
        end

        // Reset right after a read drops its rvalid; a write during reset still lands
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        tick(1'b1);
        reset = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'hA5;
        tick(1'b1);
        chk1("rst rvalid0 dropped", rvalid0, 1'b0);
        chk1("rst gnt0", gnt0, 1'b0);
        reset = 1'b0; req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        tick(1'b1);
        chk1("post-rst gnt1 latency", gnt1, 1'b1);
        tick(1'b1);
        chk8("write during reset", rdata1, 8'hA5);
        req1 = 1'b0;

        // Requester 0 takes and holds the lock while requester 1 waits 100 cycles
        req0 = 1'b1; lock0 = 1'b1; addr0 = 8'h02;
        tick(1'b1);
        tick(1'b1);
        req0 = 1'b0; req1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1);
            chk1("lock hold gnt0", gnt0, 1'b1);
        end
        req0 = 1'b1; lock0 = 1'b0;
        tick(1'b1);
        chk1("lock release gnt1", gnt1, 1'b1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            req0   = ($urandom_range(0, 3) != 0);
            we0    = 1'($urandom_range(0, 1));
            addr0  = 8'($urandom_range(0, 15));
            wdata0 = 8'($urandom_range(0, 255));
            lock0  = ($urandom_range(0, 3) == 0);
            req1   = ($urandom_range(0, 3) != 0);
            we1    = 1'($urandom_range(0, 1));
            addr1  = 8'($urandom_range(0, 15));
            wdata1 = 8'($urandom_range(0, 255));
            lock1  = ($urandom_range(0, 3) == 0);
            tick(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
